// File: rtl/etc_pkg.sv
// etc_pkg: shared types for the etc_pipe matrix-multiply slice.
//   op_e     operand/result packing mode
//   state_e  etc_pipe sequencing states
//   etc_ow   result lane width for a given operand width and guard-bit count
package etc_pkg;

   typedef enum logic [1:0] {
      OP_4X4 = 2'd0,   // 4x4 * 4x4 at W
      OP_2X4 = 2'd1,   // 2x4 * 4x2 at 2W
      OP_4X2 = 2'd2,   // 4x2 * 2x4 at 2W, two result beats
      OP_RSV = 2'd3    // reserved: zero beat, accumulator untouched
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT0 = 2'd2,
      OUT1 = 2'd3
   } state_e;

   function automatic int etc_ow(input int w, input int g);
      return 2 * w + g;
   endfunction

endpackage

// File: rtl/etc_if.sv
// etc_if: request/result handshake bundle for etc_pipe.
//   master : producer/consumer side (drives operands, out_ready)
//   slave  : etc_pipe side (drives in_ready, result beats)
// W/G here must match the W/G of the etc_pipe instance it is bound to.
interface etc_if #(
   parameter int W = 12,
   parameter int G = 4
);
   import etc_pkg::*;

   localparam int OW = etc_ow(W, G);

   logic                       in_valid;
   logic                       in_ready;
   logic [1:0]                 op;
   logic                       acc;
   logic [3:0][3:0][W-1:0]     inA;
   logic [3:0][3:0][W-1:0]     inB;
   logic                       out_valid;
   logic                       out_ready;
   logic [3:0][3:0][OW-1:0]    out;
   logic                       out_last;

   modport master (
      output in_valid, op, acc, inA, inB, out_ready,
      input  in_ready, out_valid, out, out_last
   );

   modport slave (
      input  in_valid, op, acc, inA, inB, out_ready,
      output in_ready, out_valid, out, out_last
   );

endinterface

// File: rtl/etc_mac4.sv
// etc_mac4: combinational 4-term unsigned dot product.
//   a, b : four W-bit lanes each
//   y    : sum of a[k]*b[k], full precision (2W+2 bits)
module etc_mac4 #(
   parameter int W = 12
) (
   input  logic [3:0][W-1:0] a,
   input  logic [3:0][W-1:0] b,
   output logic [2*W+1:0]    y
);
   localparam int YW = 2 * W + 2;

   always_comb begin
      y = '0;
      for (int k = 0; k < 4; k++) begin
         y = y + YW'(a[k]) * YW'(b[k]);
      end
   end

endmodule

// File: rtl/etc_pipe.sv
// etc_pipe: one-in-flight 4x4 matrix multiply/accumulate with narrow (W) and
// lane-pair wide (2W) modes.
//   clk, rst_n : clock, async active-low reset
//   bus        : etc_if.slave -- operand handshake in, result beats out
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1, waiting for an operand handshake
// CALC  | operands registered; products formed, accumulator loads on exit
// OUT0  | first (or only) result beat presented
// OUT1  | second beat of an OP_4X2 result
module etc_pipe
   import etc_pkg::*;
#(
   parameter int W = 12,
   parameter int G = 4
) (
   input logic clk,
   input logic rst_n,
   etc_if.slave bus
);
   localparam int OW = etc_ow(W, G);
   localparam int WW = 2 * OW;
   localparam logic [WW-1:0] OW_MASK = {{OW{1'b0}}, {OW{1'b1}}};

   state_e                        state_q, state_d;
   op_e                           op_q, last_op_q;
   logic                          acc_req_q, last_vld_q, acc_eff;
   logic [3:0][3:0][W-1:0]        a_q, b_q;
   // Held result matrix, one 2*OW element per C[i][j]; it is both the last
   // result and the accumulator source.
   logic [3:0][3:0][WW-1:0]       hold_q, hold_d;
   logic [3:0][3:0][OW-1:0]       out_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.in_valid) state_d = CALC;
         CALC: state_d = OUT0;
         OUT0: if (bus.out_ready) state_d = (op_q == OP_4X2) ? OUT1 : IDLE;
         OUT1: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == OUT0) || (state_q == OUT1);
   assign bus.out_last  = ((state_q == OUT0) && (op_q != OP_4X2)) || (state_q == OUT1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= OP_4X4;
         acc_req_q  <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         hold_q     <= '0;
         last_op_q  <= OP_4X4;
         last_vld_q <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.in_valid) begin
            op_q      <= op_e'(bus.op);
            acc_req_q <= bus.acc;
            a_q       <= bus.inA;
            b_q       <= bus.inB;
         end
         // Reserved op leaves both the accumulator and the last-op tag alone,
         // so a later accumulate still chains onto the previous real result.
         if (state_q == CALC && op_q != OP_RSV) begin
            hold_q     <= hold_d;
            last_op_q  <= op_q;
            last_vld_q <= 1'b1;
         end
      end
   end

   assign acc_eff = acc_req_q && last_vld_q && (op_q == last_op_q);

   // One wide unit per C[i][j]. A wide product {ah,al}*{bh,bl} is split into
   // hh<<2W + (hl+lh)<<W + ll; narrow mode only feeds the lo lanes.
   for (genvar gi = 0; gi < 4; gi++) begin : g_row
      for (genvar gj = 0; gj < 4; gj++) begin : g_col
         localparam int R0 = (2 * gi) % 4;
         localparam int R1 = (2 * gi + 1) % 4;
         localparam int C0 = (2 * gj) % 4;
         localparam int C1 = (2 * gj + 1) % 4;
         localparam bit PAIR = (gi < 2) && (gj < 2);

         logic [3:0][W-1:0] ah, al, bh, bl;
         logic [2*W+1:0]    hh, hl, lh, ll;
         logic [WW-1:0]     prod, sum;

         always_comb begin
            ah = '0;
            al = '0;
            bh = '0;
            bl = '0;
            case (op_q)
               OP_4X4: begin
                  for (int k = 0; k < 4; k++) begin
                     al[k] = a_q[gi][k];
                     bl[k] = b_q[k][gj];
                  end
               end
               OP_2X4: begin
                  if (PAIR) begin
                     for (int k = 0; k < 4; k++) begin
                        ah[k] = a_q[R1][k];
                        al[k] = a_q[R0][k];
                        bh[k] = b_q[k][C1];
                        bl[k] = b_q[k][C0];
                     end
                  end
               end
               OP_4X2: begin
                  ah[0] = a_q[gi][1];
                  al[0] = a_q[gi][0];
                  ah[1] = a_q[gi][3];
                  al[1] = a_q[gi][2];
                  bh[0] = b_q[1][gj];
                  bl[0] = b_q[0][gj];
                  bh[1] = b_q[3][gj];
                  bl[1] = b_q[2][gj];
               end
               default: ;
            endcase
         end

         etc_mac4 #(.W(W)) u_hh (.a(ah), .b(bh), .y(hh));
         etc_mac4 #(.W(W)) u_hl (.a(ah), .b(bl), .y(hl));
         etc_mac4 #(.W(W)) u_lh (.a(al), .b(bh), .y(lh));
         etc_mac4 #(.W(W)) u_ll (.a(al), .b(bl), .y(ll));

         assign prod = (WW'(hh) << (2 * W)) + (WW'(hl) << W) + (WW'(lh) << W) + WW'(ll);
         assign sum  = prod + (acc_eff ? hold_q[gi][gj] : '0);
         assign hold_d[gi][gj] = (op_q == OP_4X4) ? (sum & OW_MASK) : sum;
      end
   end

   // Result lanes are a pure function of held state, so they stay put while
   // the consumer stalls.
   always_comb begin
      out_d = '0;
      if (bus.out_valid) begin
         case (op_q)
            OP_4X4: begin
               for (int i = 0; i < 4; i++)
                  for (int j = 0; j < 4; j++)
                     out_d[i][j] = hold_q[i][j][OW-1:0];
            end
            OP_2X4: begin
               for (int i = 0; i < 2; i++)
                  for (int j = 0; j < 2; j++) begin
                     out_d[i][2*j]   = hold_q[i][j][OW-1:0];
                     out_d[i][2*j+1] = hold_q[i][j][WW-1:OW];
                  end
            end
            OP_4X2: begin
               for (int r = 0; r < 2; r++)
                  for (int j = 0; j < 4; j++) begin
                     out_d[2*r + j/2][2*(j%2)]   = hold_q[(state_q == OUT1 ? 2 : 0) + r][j][OW-1:0];
                     out_d[2*r + j/2][2*(j%2)+1] = hold_q[(state_q == OUT1 ? 2 : 0) + r][j][WW-1:OW];
                  end
            end
            default: ;
         endcase
      end
   end

   assign bus.out = out_d;

endmodule
